controle_timer: RTL and testbench

CONTROLE_TIMER -- requirements
Module: controle_timer

---
 rtl/controle_timer.sv | 149 ++++++++++++++
 tb/tb_controle_timer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/controle_timer.sv
// controle_timer: control FSM for a keypad-programmed MM:SS countdown timer.
//   The user keys in up to four digits. They shift in from the right, so the
//   last key pressed becomes the seconds-units digit. Start loads the digits
//   into external down-counters and then enables them on each 1 Hz tick.
//   Pause freezes the countdown. When the counters reach zero the alarm is
//   raised. The alarm is dismissed by start, by clear, or after ten ticks.
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   key_data/key_valid     keypad digit and its one-cycle strobe
//   start/pause/clear      level-sampled user requests
//   tick                   one-cycle 1 Hz enable
//   tc_*                   zero flags from the four digit counters
//   sec_u/sec_d/min_u/min_d  digits presented to the counters' data inputs
//   load                   one-cycle parallel-load strobe
//   count_en               decrement enable (counters' stop input)
//   alarm                  time expired
//   state                  current FSM state code
module controle_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_data,
  input  logic       key_valid,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       tick,
  input  logic       tc_sec_u,
  input  logic       tc_sec_d,
  input  logic       tc_min_u,
  input  logic       tc_min_d,
  output logic [3:0] sec_u,
  output logic [2:0] sec_d,
  output logic [3:0] min_u,
  output logic [2:0] min_d,
  output logic       load,
  output logic       count_en,
  output logic       alarm,
  output logic [2:0] state
);

  localparam logic [2:0] IDLE  = 3'b000;
  localparam logic [2:0] ENTRY = 3'b001;
  localparam logic [2:0] LOAD  = 3'b010;
  localparam logic [2:0] RUN   = 3'b011;
  localparam logic [2:0] PAUSE = 3'b100;
  localparam logic [2:0] DONE  = 3'b101;

  logic [2:0] r_state;
  logic [3:0] r_sec_u;
  logic [2:0] r_sec_d;
  logic [3:0] r_min_u;
  logic [2:0] r_min_d;
  logic [2:0] r_ndig;
  logic [3:0] r_tcnt;

  logic [2:0] w_nxt;
  logic       w_shift;
  logic       w_to_idle;
  logic       w_key_ok;
  logic       w_all_tc;
  logic       w_nonzero;

  assign w_all_tc  = tc_sec_u & tc_sec_d & tc_min_u & tc_min_d;
  assign w_nonzero = (r_sec_u != 4'd0) || (r_sec_d != 3'd0) ||
                     (r_min_u != 4'd0) || (r_min_d != 3'd0);

  // A shift moves sec_u into sec_d and min_u into min_d. Both tens digits
  // must stay within 0..5, so the key is refused if either source digit is
  // above 5.
  assign w_key_ok = key_valid && ((r_state == IDLE) || (r_state == ENTRY)) &&
                    (key_data <= 4'd9) && (r_ndig < 3'd4) &&
                    (r_sec_u <= 4'd5) && (r_min_u <= 4'd5);

  always_comb begin
    w_nxt   = r_state;
    w_shift = 1'b0;
    case (r_state)
      IDLE: if (w_key_ok) begin
        w_shift = 1'b1;
        w_nxt   = ENTRY;
      end
      ENTRY: begin
        if (clear)                  w_nxt   = IDLE;
        else if (start && w_nonzero) w_nxt  = LOAD;
        else if (w_key_ok)          w_shift = 1'b1;
      end
      LOAD: w_nxt = RUN;
      RUN: begin
        if (clear)         w_nxt = IDLE;
        else if (w_all_tc) w_nxt = DONE;
        else if (pause)    w_nxt = PAUSE;
      end
      PAUSE: begin
        if (clear)      w_nxt = IDLE;
        else if (start) w_nxt = RUN;
      end
      DONE: if (start || clear || (tick && (r_tcnt == 4'd9))) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Every way back to IDLE, including recovery from an illegal code, wipes
  // the digits and counters.
  assign w_to_idle = (w_nxt == IDLE) && (r_state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_sec_u <= 4'd0;
      r_sec_d <= 3'd0;
      r_min_u <= 4'd0;
      r_min_d <= 3'd0;
      r_ndig  <= 3'd0;
      r_tcnt  <= 4'd0;
    end else begin
      r_state <= w_nxt;
      if (w_to_idle) begin
        r_sec_u <= 4'd0;
        r_sec_d <= 3'd0;
        r_min_u <= 4'd0;
        r_min_d <= 3'd0;
        r_ndig  <= 3'd0;
        r_tcnt  <= 4'd0;
      end else begin
        if (w_shift) begin
          r_min_d <= r_min_u[2:0];
          r_min_u <= {1'b0, r_sec_d};
          r_sec_d <= r_sec_u[2:0];
          r_sec_u <= key_data;
          r_ndig  <= r_ndig + 3'd1;
        end
        if ((r_state == DONE) && tick) r_tcnt <= r_tcnt + 4'd1;
      end
    end
  end

  assign sec_u = r_sec_u;
  assign sec_d = r_sec_d;
  assign min_u = r_min_u;
  assign min_d = r_min_d;
  assign state = r_state;

  // The control strobes are decoded from state. Reset forces IDLE, so they
  // drop immediately, and nothing is left pending when reset is released.
  assign load     = (r_state == LOAD);
  assign count_en = (r_state == RUN) && tick && !w_all_tc;
  assign alarm    = (r_state == DONE);

endmodule

// File: tb/tb_controle_timer.sv
module tb_controle_timer;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_data;
  logic       key_valid, start, pause, clear, tick;
  logic       tc_sec_u, tc_sec_d, tc_min_u, tc_min_d;
  logic [3:0] sec_u, min_u;
  logic [2:0] sec_d, min_d, state;
  logic       load, count_en, alarm;

  int n_cmp = 0;
  int n_err = 0;

  controle_timer dut (
    .clk(clk), .reset(reset), .key_data(key_data), .key_valid(key_valid),
    .start(start), .pause(pause), .clear(clear), .tick(tick),
    .tc_sec_u(tc_sec_u), .tc_sec_d(tc_sec_d), .tc_min_u(tc_min_u), .tc_min_d(tc_min_d),
    .sec_u(sec_u), .sec_d(sec_d), .min_u(min_u), .min_d(min_d),
    .load(load), .count_en(count_en), .alarm(alarm), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change at the falling edge. Checks run at the falling edge or
  // just after it.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] k);
    key_data = k; key_valid = 1'b1;
    cyc();
    key_valid = 1'b0;
  endtask

  task automatic digits(input string tag, input int md, input int mu, input int sd, input int su);
    chk({tag, ".min_d"}, min_d, md);
    chk({tag, ".min_u"}, min_u, mu);
    chk({tag, ".sec_d"}, sec_d, sd);
    chk({tag, ".sec_u"}, sec_u, su);
  endtask

  task automatic set_tc(input logic v);
    tc_sec_u = v; tc_sec_d = v; tc_min_u = v; tc_min_d = v;
  endtask

  // Starts from IDLE: enters a single digit k and starts, ending in RUN.
  task automatic to_run(input logic [3:0] k);
    press(k);
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    chk("to_run.state", state, 3);
  endtask

  initial begin
    reset = 1'b1; key_data = 4'd0; key_valid = 1'b0; start = 1'b0;
    pause = 1'b0; clear = 1'b0; tick = 1'b0; set_tc(1'b0);
    #1;
    chk("rst.state", state, 0);
    chk("rst.load", load, 0);
    chk("rst.count_en", count_en, 0);
    chk("rst.alarm", alarm, 0);
    digits("rst", 0, 0, 0, 0);
    @(negedge clk); reset = 1'b0;

    // A start request in IDLE does nothing.
    start = 1'b1; cyc(); start = 1'b0;
    chk("idle_start.state", state, 0);

    // Keys 1,2,3,0 then start.
    press(4'd1); chk("k1.state", state, 1); digits("k1", 0, 0, 0, 1);
    press(4'd2); digits("k2", 0, 0, 1, 2);
    press(4'd3); press(4'd0);
    digits("k1230", 1, 2, 3, 0);
    chk("k1230.state", state, 1);
    start = 1'b1; cyc(); start = 1'b0;
    chk("load.state", state, 2);
    chk("load.pulse", load, 1);
    cyc();
    chk("run.state", state, 3);
    chk("run.load", load, 0);
    digits("run", 1, 2, 3, 0);

    // The counters are enabled only while tick is high.
    tick = 1'b1; #1 chk("run.tick1", count_en, 1);
    cyc(); tick = 1'b0; #1 chk("run.notick", count_en, 0);
    cyc(); tick = 1'b1; #1 chk("run.tick2", count_en, 1);
    // When all counters read zero, the enable is suppressed even with a tick.
    set_tc(1'b1); #1 chk("run.allzero_en", count_en, 0);
    cyc(); tick = 1'b0; set_tc(1'b0);
    chk("done.state", state, 5);
    chk("done.alarm", alarm, 1);
    chk("done.count_en", count_en, 0);
    // Start dismisses the alarm on the next edge.
    start = 1'b1; cyc(); start = 1'b0;
    chk("done_start.state", state, 0);
    chk("done_start.alarm", alarm, 0);
    digits("done_start", 0, 0, 0, 0);

    // A second key that would put a value above 5 into sec_d is rejected.
    press(4'd7); press(4'd8);
    digits("k78", 0, 0, 0, 7);
    chk("k78.state", state, 1);
    clear = 1'b1; cyc(); clear = 1'b0;
    chk("entry_clr.state", state, 0);
    digits("entry_clr", 0, 0, 0, 0);

    // A fifth key is ignored, and so is a value above 9.
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    press(4'd5);
    digits("k5th", 1, 2, 3, 4);
    clear = 1'b1; cyc(); clear = 1'b0;
    press(4'd12);
    chk("kbig.state", state, 0);
    digits("kbig", 0, 0, 0, 0);

    // In RUN, pause and clear together: clear wins.
    to_run(4'd5);
    pause = 1'b1; clear = 1'b1; cyc(); pause = 1'b0; clear = 1'b0;
    chk("run_pc.state", state, 0);
    digits("run_pc", 0, 0, 0, 0);

    // Pause alone goes to PAUSE, where the counters stay disabled; start resumes.
    to_run(4'd5);
    pause = 1'b1; cyc(); pause = 1'b0;
    chk("pause.state", state, 4);
    tick = 1'b1; #1 chk("pause.count_en", count_en, 0);
    cyc(); tick = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    chk("resume.state", state, 3);
    // In PAUSE, clear takes priority over start.
    pause = 1'b1; cyc(); pause = 1'b0;
    start = 1'b1; clear = 1'b1; cyc(); start = 1'b0; clear = 1'b0;
    chk("pause_cs.state", state, 0);

    // DONE returns to IDLE on the tenth tick.
    to_run(4'd2);
    set_tc(1'b1); cyc(); set_tc(1'b0);
    chk("done2.state", state, 5);
    for (int i = 1; i <= 9; i++) begin
      tick = 1'b1; cyc(); tick = 1'b0; cyc();
    end
    chk("done9.state", state, 5);
    chk("done9.alarm", alarm, 1);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("done10.state", state, 0);
    chk("done10.alarm", alarm, 0);

    // Reset pulsed between clock edges during RUN takes effect without an edge.
    to_run(4'd3);
    tick = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("arst.state", state, 0);
    chk("arst.count_en", count_en, 0);
    chk("arst.load", load, 0);
    chk("arst.alarm", alarm, 0);
    digits("arst", 0, 0, 0, 0);
    @(negedge clk); reset = 1'b0; tick = 1'b0;
    cyc();
    chk("arst_after.load", load, 0);
    chk("arst_after.count_en", count_en, 0);

    // A single key 0 is accepted, but start with all digits zero is ignored.
    press(4'd0);
    chk("k0.state", state, 1);
    start = 1'b1; cyc(); start = 1'b0;
    chk("k0_start.state", state, 1);
    chk("k0_start.load", load, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
